// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone prefix adder/subtractor with a valid/ready stream on both sides.
// Stage chain: input register, LEVELS prefix-combine levels (each optionally registered),
// then the output register that forms sum/cout/ovf. The whole pipeline stalls on a
// single advance signal, which is in_ready.
module prefix_adder_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign in_ready  = ~out_valid_q | out_ready;
    assign advance   = in_ready;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Per-level views of the datapath; level 0 is the input register output.
    logic [WIDTH-1:0] g_lvl  [LEVELS+1];
    logic [WIDTH-1:0] p_lvl  [LEVELS+1];
    logic [WIDTH-1:0] ps_lvl [LEVELS+1];
    logic [LEVELS:0]  c0_lvl;
    logic [LEVELS:0]  v_lvl;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g_pre;
    logic [WIDTH-1:0] p_pre;
    logic             c0;

    // Generate/propagate pre-processing; carry-in is folded into bit 0's generate so the
    // prefix tree only has to span WIDTH bits.
    always_comb begin
        b_eff    = sub ? ~b : b;
        c0       = cin ^ sub;
        g_pre    = a & b_eff;
        p_pre    = a ^ b_eff;
        g_pre[0] = g_pre[0] | (p_pre[0] & c0);
    end

    logic [WIDTH-1:0] g_in_q;
    logic [WIDTH-1:0] p_in_q;
    logic             c0_in_q;
    logic             v_in_q;

    // Input register; data only loads on an accepted beat so bubbles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_in_q  <= '0;
            p_in_q  <= '0;
            c0_in_q <= 1'b0;
            v_in_q  <= 1'b0;
        end else if (advance) begin
            v_in_q <= in_valid;
            if (in_valid) begin
                g_in_q  <= g_pre;
                p_in_q  <= p_pre;
                c0_in_q <= c0;
            end
        end
    end

    assign g_lvl[0]  = g_in_q;
    assign p_lvl[0]  = p_in_q;
    assign ps_lvl[0] = p_in_q;
    assign c0_lvl[0] = c0_in_q;
    assign v_lvl[0]  = v_in_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int unsigned Span = 1 << k;

        logic [WIDTH-1:0] g_nxt;
        logic [WIDTH-1:0] p_nxt;

        // Kogge-Stone combine at distance Span: (G,P) o (G',P') = (G | P&G', P&P').
        always_comb begin
            g_nxt = g_lvl[k];
            p_nxt = p_lvl[k];
            for (int unsigned i = Span; i < WIDTH; i++) begin
                g_nxt[i] = g_lvl[k][i] | (p_lvl[k][i] & g_lvl[k][i-Span]);
                p_nxt[i] = p_lvl[k][i] & p_lvl[k][i-Span];
            end
        end

        if (PIPE != 0) begin : g_reg
            logic [WIDTH-1:0] g_q;
            logic [WIDTH-1:0] p_q;
            logic [WIDTH-1:0] ps_q;
            logic             c0_q;
            logic             v_q;

            // Level pipeline register, held on stall, data loaded only behind a valid beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    g_q  <= '0;
                    p_q  <= '0;
                    ps_q <= '0;
                    c0_q <= 1'b0;
                    v_q  <= 1'b0;
                end else if (advance) begin
                    v_q <= v_lvl[k];
                    if (v_lvl[k]) begin
                        g_q  <= g_nxt;
                        p_q  <= p_nxt;
                        ps_q <= ps_lvl[k];
                        c0_q <= c0_lvl[k];
                    end
                end
            end

            assign g_lvl[k+1]  = g_q;
            assign p_lvl[k+1]  = p_q;
            assign ps_lvl[k+1] = ps_q;
            assign c0_lvl[k+1] = c0_q;
            assign v_lvl[k+1]  = v_q;
        end else begin : g_comb
            assign g_lvl[k+1]  = g_nxt;
            assign p_lvl[k+1]  = p_nxt;
            assign ps_lvl[k+1] = ps_lvl[k];
            assign c0_lvl[k+1] = c0_lvl[k];
            assign v_lvl[k+1]  = v_lvl[k];
        end
    end

    // After the tree, g_fin[i] is the carry out of bit i; carry into bit 0 is c0 itself.
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] carry;

    assign g_fin = g_lvl[LEVELS];
    assign carry = {g_fin[WIDTH-2:0], c0_lvl[LEVELS]};

    // Output register: sum, carry-out and signed overflow (carry into MSB vs carry out).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= v_lvl[LEVELS];
            if (v_lvl[LEVELS]) begin
                sum_q  <= ps_lvl[LEVELS] ^ carry;
                cout_q <= g_fin[WIDTH-1];
                ovf_q  <= g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
            end
        end
    end

endmodule
